// File: rtl/multdiv_controller_pkg.sv
// Shared definitions for the mult/div sequencer: FSM state encodings and
// default timing parameters.
package multdiv_controller_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_WAIT  = 2'd2,
    ST_DONE  = 2'd3
  } state_t;

  // Must exceed the divider latency (35 cycles); 2**CNT_W must exceed it.
  localparam int TIMEOUT_DEFAULT = 40;
  localparam int CNT_W_DEFAULT   = 6;

endpackage

// File: rtl/multdiv_wait_counter.sv
// Up counter for WAIT cycles: synchronous clear, count enable and a
// terminal-count flag that is high while the count equals TERM.
module multdiv_wait_counter #(
  parameter int CNT_W = 6,
  parameter int TERM  = 39
) (
  input  logic clock,
  input  logic reset,
  input  logic clear,
  input  logic enable,
  output logic term
);

  localparam logic [CNT_W-1:0] TERM_C = CNT_W'(TERM);

  logic [CNT_W-1:0] count;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (enable) begin
      count <= count + CNT_W'(1);
    end
  end

  assign term = (count == TERM_C);

endmodule

// File: rtl/multdiv_controller.sv
// Execute-stage sequencer for the shared multiplier/divider: captures one op,
// fires a single start pulse, waits for the selected unit (or a timeout) and
// returns a one-cycle writeback strobe while stalling the front of the pipe.
//
// Handshake: op_valid is held by the pipeline for as long as stall is high; an
// op is accepted on the edge where the FSM is IDLE with op_valid & ~flush, and
// its result is presented for exactly one cycle with wb_valid (stall low then,
// so the pipeline retires the op together with its result).
module multdiv_controller
  import multdiv_controller_pkg::*;
#(
  parameter int TIMEOUT = TIMEOUT_DEFAULT,
  parameter int CNT_W   = CNT_W_DEFAULT
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        op_valid,
  input  logic        op_is_div,
  input  logic [4:0]  op_rd,
  input  logic [31:0] op_A,
  input  logic [31:0] op_B,
  input  logic        flush,
  output logic        ctrl_MULT,
  output logic        ctrl_DIV,
  output logic [31:0] data_operandA,
  output logic [31:0] data_operandB,
  input  logic [31:0] mult_result,
  input  logic        mult_resultRDY,
  input  logic        mult_exception,
  input  logic [31:0] div_result,
  input  logic        div_resultRDY,
  input  logic        div_exception,
  output logic        stall,
  output logic        busy,
  output logic [4:0]  busy_rd,
  output logic        wb_valid,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        wb_exception,
  output logic        wb_is_div,
  output logic [1:0]  state_dbg
);

  state_t      state;
  logic [4:0]  cap_rd;
  logic        cap_is_div;
  logic        cnt_term;
  logic        sel_rdy;
  logic        sel_exc;
  logic [31:0] sel_result;

  multdiv_wait_counter #(
    .CNT_W (CNT_W),
    .TERM  (TIMEOUT - 1)
  ) u_wait_counter (
    .clock  (clock),
    .reset  (reset),
    .clear  (state == ST_ISSUE),
    .enable (state == ST_WAIT),
    .term   (cnt_term)
  );

  // Only the unit that was started may complete the op; the other is ignored.
  assign sel_rdy    = cap_is_div ? div_resultRDY  : mult_resultRDY;
  assign sel_exc    = cap_is_div ? div_exception  : mult_exception;
  assign sel_result = cap_is_div ? div_result     : mult_result;

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state         <= ST_IDLE;
      cap_rd        <= '0;
      cap_is_div    <= 1'b0;
      data_operandA <= '0;
      data_operandB <= '0;
      ctrl_MULT     <= 1'b0;
      ctrl_DIV      <= 1'b0;
      wb_valid      <= 1'b0;
      wb_rd         <= '0;
      wb_data       <= '0;
      wb_exception  <= 1'b0;
      wb_is_div     <= 1'b0;
    end else begin
      ctrl_MULT <= 1'b0;
      ctrl_DIV  <= 1'b0;
      wb_valid  <= 1'b0;
      if (flush) begin
        state <= ST_IDLE;
      end else begin
        case (state)
          ST_IDLE: begin
            if (op_valid) begin
              cap_rd        <= op_rd;
              cap_is_div    <= op_is_div;
              data_operandA <= op_A;
              data_operandB <= op_B;
              // Start pulse is registered so it is high exactly in ISSUE.
              ctrl_DIV      <= op_is_div;
              ctrl_MULT     <= ~op_is_div;
              state         <= ST_ISSUE;
            end
          end
          ST_ISSUE: begin
            state <= ST_WAIT;
          end
          ST_WAIT: begin
            if (sel_rdy) begin
              wb_valid     <= 1'b1;
              wb_rd        <= cap_rd;
              wb_data      <= sel_result;
              wb_exception <= sel_exc;
              wb_is_div    <= cap_is_div;
              state        <= ST_DONE;
            end else if (cnt_term) begin
              wb_valid     <= 1'b1;
              wb_rd        <= cap_rd;
              wb_data      <= '0;
              wb_exception <= 1'b1;
              wb_is_div    <= cap_is_div;
              state        <= ST_DONE;
            end
          end
          ST_DONE: begin
            state <= ST_IDLE;
          end
          default: begin
            state <= ST_IDLE;
          end
        endcase
      end
    end
  end

  // Reset is folded in so every output is low while reset is asserted.
  assign stall = ~reset & ~flush &
                 (((state == ST_IDLE) & op_valid) | (state == ST_ISSUE) | (state == ST_WAIT));
  assign busy      = (state != ST_IDLE);
  assign busy_rd   = busy ? cap_rd : 5'd0;
  assign state_dbg = state;

endmodule

// File: tb/tb_multdiv_controller.sv
// Directed bench for multdiv_controller: behavioural mult/div unit model,
// expected-result queue and a single checking task feeding the summary.
module tb_multdiv_controller;

  logic        clock = 1'b0;
  logic        reset;
  logic        op_valid;
  logic        op_is_div;
  logic [4:0]  op_rd;
  logic [31:0] op_A;
  logic [31:0] op_B;
  logic        flush;
  logic        ctrl_MULT;
  logic        ctrl_DIV;
  logic [31:0] data_operandA;
  logic [31:0] data_operandB;
  logic [31:0] mult_result;
  logic        mult_resultRDY;
  logic        mult_exception;
  logic [31:0] div_result;
  logic        div_resultRDY;
  logic        div_exception;
  logic        stall;
  logic        busy;
  logic [4:0]  busy_rd;
  logic        wb_valid;
  logic [4:0]  wb_rd;
  logic [31:0] wb_data;
  logic        wb_exception;
  logic        wb_is_div;
  logic [1:0]  state_dbg;

  int n_cmp = 0;
  int n_bad = 0;
  logic [31:0] exp_q[$];

  multdiv_controller dut (
    .clock          (clock),
    .reset          (reset),
    .op_valid       (op_valid),
    .op_is_div      (op_is_div),
    .op_rd          (op_rd),
    .op_A           (op_A),
    .op_B           (op_B),
    .flush          (flush),
    .ctrl_MULT      (ctrl_MULT),
    .ctrl_DIV       (ctrl_DIV),
    .data_operandA  (data_operandA),
    .data_operandB  (data_operandB),
    .mult_result    (mult_result),
    .mult_resultRDY (mult_resultRDY),
    .mult_exception (mult_exception),
    .div_result     (div_result),
    .div_resultRDY  (div_resultRDY),
    .div_exception  (div_exception),
    .stall          (stall),
    .busy           (busy),
    .busy_rd        (busy_rd),
    .wb_valid       (wb_valid),
    .wb_rd          (wb_rd),
    .wb_data        (wb_data),
    .wb_exception   (wb_exception),
    .wb_is_div      (wb_is_div),
    .state_dbg      (state_dbg)
  );

  // Clock / reset
  always #5 clock = ~clock;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, got, exp);
    end
  endtask

  // Driver tasks
  task automatic unit_idle();
    mult_resultRDY = 1'b0;
    mult_result    = '0;
    mult_exception = 1'b0;
    div_resultRDY  = 1'b0;
    div_result     = '0;
    div_exception  = 1'b0;
  endtask

  task automatic drive_op(input logic is_div, input logic [4:0] rd,
                          input logic [31:0] a, input logic [31:0] b);
    op_valid  = 1'b1;
    op_is_div = is_div;
    op_rd     = rd;
    op_A      = a;
    op_B      = b;
  endtask

  task automatic check_wb_from_queue(input string tag);
    logic [31:0] exp;
    if (exp_q.size() == 0) begin
      check_val({tag, "_unexpected_wb"}, 32'd1, 32'd0);
    end else begin
      exp = exp_q.pop_front();
      check_val({tag, "_wb_data"}, wb_data, exp);
    end
  endtask

  // One complete op; delay < 0 means the unit never answers (timeout).
  task automatic run_op(input string tag, input logic is_div, input logic [4:0] rd,
                        input logic [31:0] a, input logic [31:0] b, input int delay,
                        input logic [31:0] res, input logic exc,
                        input logic [31:0] exp_data, input logic exp_exc);
    int k = 0;
    bit pulsed = 0;
    int stall_cnt = 0;
    int n_mult = 0;
    int n_div = 0;
    int n_both = 0;
    int n_wb = 0;
    int wb_iter = -1;
    int exp_lat;
    exp_lat = (delay < 0) ? 42 : delay + 2;
    exp_q.push_back(exp_data);
    @(negedge clock);
    drive_op(is_div, rd, a, b);
    #1;
    if (stall) stall_cnt++;
    for (int it = 1; it <= 100 && n_wb == 0; it++) begin
      @(negedge clock);
      if (pulsed) k++;
      unit_idle();
      if (pulsed && k == delay) begin
        if (is_div) begin
          div_resultRDY = 1'b1; div_result = res; div_exception = exc;
        end else begin
          mult_resultRDY = 1'b1; mult_result = res; mult_exception = exc;
        end
      end
      #1;
      if (ctrl_MULT) n_mult++;
      if (ctrl_DIV) n_div++;
      if (ctrl_MULT && ctrl_DIV) n_both++;
      if ((ctrl_MULT || ctrl_DIV) && !pulsed) begin
        pulsed = 1;
        k = 0;
        check_val({tag, "_opA"}, data_operandA, a);
        check_val({tag, "_opB"}, data_operandB, b);
        check_val({tag, "_busy_rd"}, {27'd0, busy_rd}, {27'd0, rd});
      end
      if (stall) stall_cnt++;
      if (wb_valid) begin
        n_wb++;
        wb_iter = it;
        check_wb_from_queue(tag);
        check_val({tag, "_wb_rd"}, {27'd0, wb_rd}, {27'd0, rd});
        check_val({tag, "_wb_exc"}, {31'd0, wb_exception}, {31'd0, exp_exc});
        check_val({tag, "_wb_is_div"}, {31'd0, wb_is_div}, {31'd0, is_div});
        check_val({tag, "_stall_done"}, {31'd0, stall}, 32'd0);
        op_valid = 1'b0;
      end
    end
    if (n_wb == 0) begin
      check_val({tag, "_wb_seen"}, 32'd0, 32'd1);
      void'(exp_q.pop_front());
      op_valid = 1'b0;
    end
    check_val({tag, "_mult_pulses"}, n_mult, {31'd0, ~is_div});
    check_val({tag, "_div_pulses"}, n_div, {31'd0, is_div});
    check_val({tag, "_both_pulses"}, n_both, 32'd0);
    check_val({tag, "_latency"}, wb_iter, exp_lat);
    check_val({tag, "_stall_cycles"}, stall_cnt, exp_lat);
    @(negedge clock);
    unit_idle();
    #1;
    check_val({tag, "_wb_one_cycle"}, {31'd0, wb_valid}, 32'd0);
    check_val({tag, "_idle_after"}, {31'd0, busy}, 32'd0);
    check_val({tag, "_wb_hold"}, wb_data, exp_data);
  endtask

  initial begin
    int k;
    int k2;
    bit pulsed;
    bit p2;
    int n_wb;
    int n_mult;
    int n_div;
    int n_both;

    reset = 1'b1;
    flush = 1'b0;
    op_valid = 1'b0;
    op_is_div = 1'b0;
    op_rd = '0;
    op_A = '0;
    op_B = '0;
    unit_idle();
    repeat (2) @(negedge clock);
    #1;
    check_val("rst_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);
    check_val("rst_stall_busy", {30'd0, stall, busy}, 32'd0);
    check_val("rst_wb", {26'd0, wb_valid, wb_rd}, 32'd0);
    check_val("rst_wb_data", wb_data, 32'd0);
    check_val("rst_opA", data_operandA, 32'd0);
    check_val("rst_state", {30'd0, state_dbg}, 32'd0);
    @(negedge clock);
    reset = 1'b0;

    // Directed ops: 7*-3, 100/-7, 5/0 with exception, div that never answers.
    run_op("mul_7x-3",  1'b0, 5'd5,  32'd7,   32'hFFFF_FFFD, 3,  32'hFFFF_FFEB, 1'b0, 32'hFFFF_FFEB, 1'b0);
    run_op("div_100_-7", 1'b1, 5'd17, 32'd100, 32'hFFFF_FFF9, 35, 32'hFFFF_FFF2, 1'b0, 32'hFFFF_FFF2, 1'b0);
    run_op("div_by0",   1'b1, 5'd0,  32'd5,   32'd0,         35, 32'd0,         1'b1, 32'd0,         1'b1);
    run_op("div_tmo",   1'b1, 5'd20, 32'd9,   32'd3,         -1, 32'd3,         1'b0, 32'd0,         1'b1);

    // flush together with op_valid in IDLE: no capture
    @(negedge clock);
    drive_op(1'b0, 5'd7, 32'd1, 32'd2);
    flush = 1'b1;
    #1;
    check_val("flush_idle_stall", {31'd0, stall}, 32'd0);
    @(negedge clock);
    flush = 1'b0;
    op_valid = 1'b0;
    #1;
    check_val("flush_idle_busy", {31'd0, busy}, 32'd0);
    check_val("flush_idle_ctrl", {30'd0, ctrl_MULT, ctrl_DIV}, 32'd0);

    // Flush in WAIT cycle 10, new mult right after, stray div RDY at 35.
    exp_q.push_back(32'd48);
    k = 0; k2 = 0; pulsed = 0; p2 = 0;
    n_wb = 0; n_mult = 0; n_div = 0; n_both = 0;
    @(negedge clock);
    drive_op(1'b1, 5'd9, 32'd200, 32'd3);
    for (int it = 1; it <= 60; it++) begin
      @(negedge clock);
      if (pulsed) k++;
      if (p2) k2++;
      unit_idle();
      flush = 1'b0;
      if (pulsed && k == 10) flush = 1'b1;
      if (pulsed && k == 11) drive_op(1'b0, 5'd12, 32'd6, 32'd8);
      if (p2 && k2 == 4) begin
        mult_resultRDY = 1'b1; mult_result = 32'd48;
      end
      if (pulsed && k == 35) begin
        div_resultRDY = 1'b1; div_result = 32'd66;
      end
      #1;
      if (pulsed && k == 10) check_val("flush_wait_stall", {31'd0, stall}, 32'd0);
      if (ctrl_DIV) n_div++;
      if (ctrl_MULT) n_mult++;
      if (ctrl_MULT && ctrl_DIV) n_both++;
      if (ctrl_DIV && !pulsed) begin
        pulsed = 1; k = 0;
      end
      if (ctrl_MULT && !p2) begin
        p2 = 1; k2 = 0;
        check_val("after_flush_opA", data_operandA, 32'd6);
        check_val("after_flush_opB", data_operandB, 32'd8);
        check_val("after_flush_busy_rd", {27'd0, busy_rd}, 32'd12);
      end
      if (wb_valid) begin
        n_wb++;
        check_wb_from_queue("after_flush");
        check_val("after_flush_wb_rd", {27'd0, wb_rd}, 32'd12);
        op_valid = 1'b0;
      end
      if (pulsed && k == 36) check_val("stray_rdy_busy", {31'd0, busy}, 32'd0);
    end
    check_val("flush_wb_count", n_wb, 32'd1);
    check_val("flush_div_pulses", n_div, 32'd1);
    check_val("flush_mult_pulses", n_mult, 32'd1);
    check_val("flush_both_pulses", n_both, 32'd0);

    // Wrong-unit RDY during a div, then async reset mid-WAIT.
    k = 0; pulsed = 0; n_wb = 0;
    @(negedge clock);
    unit_idle();
    drive_op(1'b1, 5'd3, 32'd50, 32'd5);
    for (int it = 1; it <= 50; it++) begin
      @(negedge clock);
      if (pulsed) k++;
      unit_idle();
      if (pulsed && k == 5) begin
        mult_resultRDY = 1'b1; mult_result = 32'd123;
      end
      if (pulsed && k == 10) reset = 1'b1;
      if (pulsed && k == 11) begin
        reset = 1'b0; op_valid = 1'b0;
      end
      if (pulsed && k == 35) begin
        div_resultRDY = 1'b1; div_result = 32'd10;
      end
      #1;
      if (ctrl_DIV && !pulsed) begin
        pulsed = 1; k = 0;
      end
      if (wb_valid) n_wb++;
      if (pulsed && k == 6) begin
        check_val("wrong_rdy_state", {30'd0, state_dbg}, 32'd2);
        check_val("wrong_rdy_busy", {31'd0, busy}, 32'd1);
      end
      if (pulsed && k == 10) begin
        check_val("areset_busy_stall", {30'd0, busy, stall}, 32'd0);
        check_val("areset_busy_rd", {27'd0, busy_rd}, 32'd0);
        check_val("areset_opA", data_operandA, 32'd0);
        check_val("areset_wb_data", wb_data, 32'd0);
        check_val("areset_wb_rd", {27'd0, wb_rd}, 32'd0);
      end
      if (pulsed && k == 36) check_val("areset_late_rdy_busy", {31'd0, busy}, 32'd0);
    end
    check_val("areset_no_wb", n_wb, 32'd0);
    check_val("queue_empty", exp_q.size(), 32'd0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
